// File: rtl/pika_mem_responder.sv
// Word-array responder for the PikaRISC imem (fetch) and dmem (load/store) ports.
// Define PIKA_MEM_CLEAR_EN to zero the whole array after reset before reporting ready.
module pika_mem_responder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    input  logic [31:0] dmem_addr,
    input  logic        dmem_write_en,
    input  logic [31:0] dmem_val_out,
    output logic [31:0] dmem_val_in,
    output logic        mem_ready,
    output logic        addr_fault,
    output logic [7:0]  fault_count
);
    localparam int unsigned Depth = 2 ** ADDR_W;

`ifdef PIKA_MEM_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;
    localparam state_e StReset = StClear;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
`else
    typedef enum logic [0:0] {StInit, StRun} state_e;
    localparam state_e StReset = StInit;
`endif

    state_e state_q, state_d;

    logic [31:0]       mem [Depth];
    logic [ADDR_W-1:0] imem_idx, dmem_idx;
    logic              imem_fault, dmem_fault;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       imem_data_d, dmem_val_in_d;
    logic              addr_fault_d;
    logic [7:0]        fault_count_d;

    assign imem_idx   = imem_addr[ADDR_W+1:2];
    assign dmem_idx   = dmem_addr[ADDR_W+1:2];
    assign imem_fault = (imem_addr[1:0] != 2'b00) || ((imem_addr >> (ADDR_W + 2)) != 32'd0);
    assign dmem_fault = (dmem_addr[1:0] != 2'b00) || ((dmem_addr >> (ADDR_W + 2)) != 32'd0);
    assign mem_ready  = (state_q == StRun);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StReset;
`ifdef PIKA_MEM_CLEAR_EN
            clr_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef PIKA_MEM_CLEAR_EN
            clr_idx_q <= clr_idx_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef PIKA_MEM_CLEAR_EN
        clr_idx_d = clr_idx_q;
        // Counter parks at DEPTH-1 rather than wrapping; only reset restarts it.
        if (state_q == StClear) begin
            if (&clr_idx_q) begin
                state_d = StRun;
            end else begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
            end
        end
`else
        if (state_q == StInit) begin
            state_d = StRun;
        end
`endif
    end

    always_comb begin
        mem_we        = 1'b0;
        mem_waddr     = dmem_idx;
        mem_wdata     = dmem_val_out;
        imem_data_d   = '0;
        dmem_val_in_d = '0;
        addr_fault_d  = 1'b0;
        fault_count_d = fault_count;
`ifdef PIKA_MEM_CLEAR_EN
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
        end
`endif
        if (state_q == StRun) begin
            mem_we = dmem_write_en && !dmem_fault;
            if (!dmem_fault) begin
                dmem_val_in_d = mem[dmem_idx];
            end
            // Fetch of a word being stored this cycle sees the new data.
            if (!imem_fault) begin
                imem_data_d = (mem_we && (imem_idx == dmem_idx)) ? dmem_val_out : mem[imem_idx];
            end
            addr_fault_d = imem_fault || dmem_fault;
            if (addr_fault_d && (fault_count != 8'hFF)) begin
                fault_count_d = fault_count + 8'd1;
            end
        end
    end

    // Array is deliberately not reset; only the clear engine or stores change it.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_data   <= '0;
            dmem_val_in <= '0;
            addr_fault  <= 1'b0;
            fault_count <= '0;
        end else begin
            imem_data   <= imem_data_d;
            dmem_val_in <= dmem_val_in_d;
            addr_fault  <= addr_fault_d;
            fault_count <= fault_count_d;
        end
    end

endmodule
